ibex_alu_pext_addsub: RTL and testbench
=======================================

// Module: ibex_alu_pext_addsub
// PURPOSE
// - Registered SIMD add/sub datapath for Zpn ops. Consumes the decoded per-op control bundle (width32/width8/signed/alu_sub).
// - Produces wrapped, saturating (K*) or halving (R*) results for 8/16/32-bit lanes, including cross (CRAS/CRSA) forms.
// - Keeps the sticky OV (vxsat) flag. Sits between the ALU operand muxes and the writeback mux; valid/ready on both sides.
// PARAMETERS
// - none (datapath fixed at 32 bits, one output register stage)
// PORTS
// - clk_i          in   1   clock
// - rst_i          in   1   reset, synchronous, active-high
// - valid_i        in   1   request valid
// - ready_o        out  1   request accepted when valid_i && ready_o
// - operand_a_i    in   32  rs1
// - operand_b_i    in   32  rs2
// - width32_i      in   1   single 32-bit lane
// - width8_i       in   1   four 8-bit lanes (neither width set: two 16-bit lanes)
// - signed_ops_i   in   1   signed lane arithmetic
// - alu_sub_i      in   2   [1]: upper-half lanes subtract; [0]: lower-half lanes subtract
// - mode_i         in   2   pext_as_mode_e: WRAP=0, SAT=1, HALVE=2 (3 illegal, treated as WRAP)
// - cross_i        in   1   swap 16-bit halves of operand_b before use (16-bit only)
// - valid_o        out  1   result valid
// - ready_i        in   1   consumer accepts result when valid_o && ready_i
// - result_o       out  32  lane results
// - ov_o           out  1   this result saturated (SAT mode only)
// - vxsat_o        out  1   sticky saturation flag (CSR view)
// - vxsat_we_i     in   1   CSR write strobe
// - vxsat_wdata_i  in   1   CSR write data
// BEHAVIOUR
// - Reset: valid_o=0, result_o=0, ov_o=0, vxsat_o=0. Reset mid-operation discards any held result.
// - ready_o = !valid_o || ready_i, combinational.
// - Latency 1 cycle: accept in cycle N, valid_o high in N+1. Result, ov_o held stable while valid_o && !ready_i.
// - Back-to-back: accept and output handshake in the same cycle loads the new result. No bubble at full throughput.
// - Lanes:
//   - width32_i: one 32-bit lane, uses alu_sub_i[0].
//   - width8_i: bytes 3,2 use alu_sub_i[1]; bytes 1,0 use alu_sub_i[0].
//   - else 16-bit: H uses [1], L uses [0].
//   - If width32_i and width8_i are both set, width32_i wins.
// - Per lane of width W:
//   - a,b extended to W+1 bits (sign-extend if signed_ops_i, else zero-extend).
//   - e = a+b or a-b (W+1 bits). No carry crosses a lane boundary.
// - WRAP: r = e[W-1:0], ov=0.
// - HALVE: r = e[W:1], for signed and unsigned alike. ov=0.
// - SAT, signed: overflow when e[W]!=e[W-1]; clamp to 2^(W-1)-1 if e[W]==0, else -2^(W-1).
// - SAT, unsigned add: e[W]=1 -> all ones. Unsigned sub: e[W]=1 -> 0.
// - ov_o = OR of lane overflows.
// - cross_i: b' = {b[15:0], b[31:16]}. Ignored unless 16-bit lanes.
// - vxsat_q next = (vxsat_we_i ? vxsat_wdata_i : vxsat_q) | (valid_o && ready_i && ov_o).
//   - Simultaneous CSR clear and saturating retire leaves vxsat=1.
// - valid_i is ignored while !ready_o. Inputs are sampled only on accept.
// STRUCTURE
// - ibex_pkg_pext: typedef enum logic [1:0] pext_as_mode_e {PEXT_AS_WRAP, PEXT_AS_SAT, PEXT_AS_HALVE}.
// - ibex_pkg_pext: localparams PEXT_LANE8_MAX / MIN, PEXT_LANE16_MAX / MIN.
// - Sub-module ibex_alu_pext_simd_adder (combinational):
//   - 4x9-bit segmented adder with carry-kill per lane width and per-byte sub/invert.
//   - Returns the W+1-bit extended sums.
// - Top holds the saturation/halving mux, output register, handshake and vxsat register.
// TESTING
// - KADD16 signed SAT, a=0x7FFF_0001, b=0x0001_0001 -> result 0x7FFF_0002, ov_o=1, vxsat 0->1 on retire.
// - UKSUB8 unsigned SAT, sub=11, a=0x0010_FF05, b=0x2001_0006 -> 0x000F_FF00, ov_o=1.
// - RSUBW signed HALVE, a=0x8000_0000, b=0x0000_0001 -> 0xBFFF_FFFF, ov_o=0.
//   - URSUB16 unsigned HALVE, a=0x0000_0000, b=0x0002_0002 -> 0xFFFF_FFFF.
// - CRAS16 WRAP, cross=1, sub=01, a=0x0005_0009, b=0x0003_0004 -> H=5+4=0x0009, L=9-3=0x0006.
// - Backpressure: ready_i=0 for 3 cycles after valid_o. result_o stable, ready_o=0, new valid_i not taken.
//   - Then ready_i=1 with valid_i=1: same-cycle accept, next result valid the following cycle.
// - vxsat_we_i=1, wdata=0 in the same cycle as a saturating retire -> vxsat_o=1.
//   - rst_i with valid_o=1 -> valid_o=0, vxsat_o=0 next cycle.

Source files
------------

// File: rtl/ibex_alu_pext_addsub_pkg.sv
// Shared types, lane limits and the per-lane wrap/saturate/halve selector
// for the packed-SIMD add/sub datapath.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        PEXT_AS_WRAP  = 2'd0,
        PEXT_AS_SAT   = 2'd1,
        PEXT_AS_HALVE = 2'd2
    } pext_as_mode_e;

    localparam logic [31:0] PEXT_LANE8_MAX  = 32'h0000_007F;
    localparam logic [31:0] PEXT_LANE8_MIN  = 32'h0000_0080;
    localparam logic [31:0] PEXT_LANE16_MAX = 32'h0000_7FFF;
    localparam logic [31:0] PEXT_LANE16_MIN = 32'h0000_8000;
    localparam logic [31:0] PEXT_LANE32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] PEXT_LANE32_MIN = 32'h8000_0000;

    // e holds the (w+1)-bit extended sum, zero above bit w; returns {ov, lane result}
    function automatic logic [32:0] pext_lane_result(
        input logic [32:0]   e,
        input logic [5:0]    w,
        input pext_as_mode_e mode,
        input logic          sgn,
        input logic          sub
    );
        logic [31:0] mask;
        logic [31:0] smax;
        logic [31:0] smin;
        logic [31:0] r;
        logic        ov;
        mask = (w >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (w)
            6'd8:    begin smax = PEXT_LANE8_MAX;  smin = PEXT_LANE8_MIN;  end
            6'd16:   begin smax = PEXT_LANE16_MAX; smin = PEXT_LANE16_MIN; end
            default: begin smax = PEXT_LANE32_MAX; smin = PEXT_LANE32_MIN; end
        endcase
        r  = e[31:0] & mask;
        ov = 1'b0;
        case (mode)
            PEXT_AS_HALVE: r = e[32:1] & mask;
            PEXT_AS_SAT: begin
                if (sgn) begin
                    if (e[w] != e[w - 6'd1]) begin
                        ov = 1'b1;
                        r  = e[w] ? smin : smax;
                    end
                end else if (e[w]) begin
                    ov = 1'b1;
                    r  = sub ? 32'd0 : mask;
                end
            end
            default: r = e[31:0] & mask;
        endcase
        return {ov, r};
    endfunction

endpackage

// File: rtl/ibex_alu_pext_addsub_if.sv
// Request/result bundle between the operand muxes, the SIMD add/sub unit and writeback.
interface ibex_alu_pext_addsub_if;

    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        width32_i;
    logic        width8_i;
    logic        signed_ops_i;
    logic [1:0]  alu_sub_i;
    logic [1:0]  mode_i;
    logic        cross_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        ov_o;
    logic        vxsat_o;
    logic        vxsat_we_i;
    logic        vxsat_wdata_i;

    modport slave (
        input  valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_ops_i,
               alu_sub_i, mode_i, cross_i, ready_i, vxsat_we_i, vxsat_wdata_i,
        output ready_o, valid_o, result_o, ov_o, vxsat_o
    );

    modport master (
        output valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_ops_i,
               alu_sub_i, mode_i, cross_i, ready_i, vxsat_we_i, vxsat_wdata_i,
        input  ready_o, valid_o, result_o, ov_o, vxsat_o
    );

endinterface

// File: rtl/ibex_alu_pext_addsub_simd_adder.sv
// Four 9-bit byte segments; carries are killed at lane boundaries and each byte
// can invert b for subtraction. ext[k] is the extension bit if byte k tops a lane.
module ibex_alu_pext_simd_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  sub_byte,
    input  logic [3:0]  kill,
    input  logic        sgn,
    output logic [31:0] sum,
    output logic [3:0]  ext
);

    logic [8:0] seg;
    logic [7:0] b_inv;
    logic       carry;
    logic       cin;

    always_comb begin
        sum   = '0;
        ext   = '0;
        seg   = '0;
        b_inv = '0;
        carry = 1'b0;
        cin   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b_inv = b[8*k +: 8] ^ {8{sub_byte[k]}};
            cin   = kill[k] ? sub_byte[k] : carry;
            seg   = {1'b0, a[8*k +: 8]} + {1'b0, b_inv} + {8'd0, cin};
            sum[8*k +: 8] = seg[7:0];
            // Sum bit of the extended operands one position above the byte MSB
            ext[k] = (sgn & a[8*k+7]) ^ ((sgn & b[8*k+7]) ^ sub_byte[k]) ^ seg[8];
            carry  = seg[8];
        end
    end

endmodule

// File: rtl/ibex_alu_pext_addsub.sv
// Registered SIMD add/sub stage: lane post-processing, output register with
// valid/ready handshake, and the sticky vxsat flag.
module ibex_alu_pext_addsub
    import ibex_pkg_pext::*;
(
    input logic                   clk_i,
    input logic                   rst_i,
    ibex_alu_pext_addsub_if.slave bus
);

    logic          w16;
    logic [31:0]   b_eff;
    logic [3:0]    sub_byte;
    logic [3:0]    kill;
    logic [31:0]   sum;
    logic [3:0]    ext;
    logic [31:0]   res_d;
    logic          ov_d;
    logic [32:0]   lane;
    pext_as_mode_e mode;
    logic          accept;
    logic          retire_ov;

    assign w16      = !bus.width32_i && !bus.width8_i;
    assign b_eff    = (w16 && bus.cross_i) ? {bus.operand_b_i[15:0], bus.operand_b_i[31:16]}
                                           : bus.operand_b_i;
    assign sub_byte = bus.width32_i ? {4{bus.alu_sub_i[0]}}
                                    : {bus.alu_sub_i[1], bus.alu_sub_i[1], bus.alu_sub_i[0], bus.alu_sub_i[0]};
    assign kill     = bus.width32_i ? 4'b0001 : (bus.width8_i ? 4'b1111 : 4'b0101);
    assign mode     = pext_as_mode_e'(bus.mode_i);

    assign bus.ready_o = !bus.valid_o || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign retire_ov   = bus.valid_o && bus.ready_i && bus.ov_o;

    ibex_alu_pext_simd_adder u_adder (
        .a        (bus.operand_a_i),
        .b        (b_eff),
        .sub_byte (sub_byte),
        .kill     (kill),
        .sgn      (bus.signed_ops_i),
        .sum      (sum),
        .ext      (ext)
    );

    always_comb begin
        res_d = '0;
        ov_d  = 1'b0;
        lane  = '0;
        if (bus.width32_i) begin
            lane  = pext_lane_result({ext[3], sum}, 6'd32, mode, bus.signed_ops_i, sub_byte[0]);
            res_d = lane[31:0];
            ov_d  = lane[32];
        end else if (bus.width8_i) begin
            for (int k = 0; k < 4; k++) begin
                lane = pext_lane_result({24'd0, ext[k], sum[8*k +: 8]}, 6'd8, mode,
                                        bus.signed_ops_i, sub_byte[k]);
                res_d[8*k +: 8] = lane[7:0];
                ov_d = ov_d | lane[32];
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                lane = pext_lane_result({16'd0, ext[2*l+1], sum[16*l +: 16]}, 6'd16, mode,
                                        bus.signed_ops_i, sub_byte[2*l+1]);
                res_d[16*l +: 16] = lane[15:0];
                ov_d = ov_d | lane[32];
            end
        end
    end

    // A CSR write and a saturating retire in the same cycle still leave vxsat set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.valid_o  <= 1'b0;
            bus.result_o <= '0;
            bus.ov_o     <= 1'b0;
            bus.vxsat_o  <= 1'b0;
        end else begin
            if (accept) begin
                bus.valid_o  <= 1'b1;
                bus.result_o <= res_d;
                bus.ov_o     <= ov_d;
            end else if (bus.ready_i) begin
                bus.valid_o  <= 1'b0;
            end
            bus.vxsat_o <= (bus.vxsat_we_i ? bus.vxsat_wdata_i : bus.vxsat_o) | retire_ov;
        end
    end

endmodule

// File: tb/tb_ibex_alu_pext_addsub.sv
// Directed + random bench: an arithmetic lane model feeds a scoreboard that is
// checked against every presented result, alongside handshake and vxsat models.
module tb_ibex_alu_pext_addsub;

    typedef struct packed {
        logic [31:0] r;
        logic        ov;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic exp_valid;
    logic exp_ready;
    logic exp_vx;

    ibex_alu_pext_addsub_if bus ();

    ibex_alu_pext_addsub dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic w32, input logic w8, input logic sg,
                                   input logic [1:0] sub, input logic [1:0] mode,
                                   input logic cr);
        exp_t        res;
        int          w;
        int          n;
        int          lo;
        logic [31:0] bb;
        longint      mask, x, y, e, rv, smax, smin;
        logic        s;
        res.r  = '0;
        res.ov = 1'b0;
        bb   = (cr && !w32 && !w8) ? {b[15:0], b[31:16]} : b;
        w    = w32 ? 32 : (w8 ? 8 : 16);
        n    = 32 / w;
        mask = (longint'(1) << w) - 1;
        for (int l = 0; l < n; l++) begin
            lo = l * w;
            x  = longint'(a >> lo) & mask;
            y  = longint'(bb >> lo) & mask;
            if (sg) begin
                if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
                if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
            end
            s  = w32 ? sub[0] : ((lo >= 16) ? sub[1] : sub[0]);
            e  = s ? (x - y) : (x + y);
            rv = e;
            if (mode == 2'd2) begin
                rv = e >>> 1;
            end else if (mode == 2'd1) begin
                if (sg) begin
                    smax = (longint'(1) << (w - 1)) - 1;
                    smin = -(longint'(1) << (w - 1));
                    if (e > smax) begin rv = smax; res.ov = 1'b1; end
                    else if (e < smin) begin rv = smin; res.ov = 1'b1; end
                end else begin
                    if (e < 0) begin rv = 0; res.ov = 1'b1; end
                    else if (e > mask) begin rv = mask; res.ov = 1'b1; end
                end
            end
            res.r = res.r | (32'(rv & mask) << lo);
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare DUT state before the edge, then advance the models across it
    task automatic check_output();
        logic retire;
        logic ret_ov;
        exp_ready = !exp_valid || bus.ready_i;
        check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
        check("ready_o", 32'(bus.ready_o), 32'(exp_ready));
        check("vxsat_o", 32'(bus.vxsat_o), 32'(exp_vx));
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                check("result_o", bus.result_o, sb_q[0].r);
                check("ov_o", 32'(bus.ov_o), 32'(sb_q[0].ov));
            end
        end
        retire = exp_valid && bus.ready_i;
        ret_ov = (retire && sb_q.size() > 0) ? sb_q[0].ov : 1'b0;
        if (rst) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_vx    = 1'b0;
        end else begin
            exp_vx = (bus.vxsat_we_i ? bus.vxsat_wdata_i : exp_vx) | ret_ov;
            if (retire && sb_q.size() > 0) void'(sb_q.pop_front());
            if (bus.valid_i && exp_ready) begin
                sb_q.push_back(model(bus.operand_a_i, bus.operand_b_i, bus.width32_i,
                                     bus.width8_i, bus.signed_ops_i, bus.alu_sub_i,
                                     bus.mode_i, bus.cross_i));
                exp_valid = 1'b1;
            end else if (bus.ready_i) begin
                exp_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic w32, input logic w8, input logic sg,
                                  input logic [1:0] sub, input logic [1:0] mode,
                                  input logic cr, input logic v, input logic rdy);
        bus.operand_a_i  = a;
        bus.operand_b_i  = b;
        bus.width32_i    = w32;
        bus.width8_i     = w8;
        bus.signed_ops_i = sg;
        bus.alu_sub_i    = sub;
        bus.mode_i       = mode;
        bus.cross_i      = cr;
        bus.valid_i      = v;
        bus.ready_i      = rdy;
        tick();
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_valid = 1'b0;
        exp_vx    = 1'b0;
        rst       = 1'b1;
        bus.vxsat_we_i    = 1'b0;
        bus.vxsat_wdata_i = 1'b0;
        $display("[TB] start");
        idle(1'b1);
        idle(1'b1);
        rst = 1'b0;
        check("reset_result", bus.result_o, 32'h0);
        check("reset_ov", 32'(bus.ov_o), 32'h0);
        check("reset_vxsat", 32'(bus.vxsat_o), 32'h0);

        // Back-to-back directed ops: KADD16, UKSUB8, RSUBW, URSUB16, CRAS16
        apply_stimulus(32'h7FFF_0001, 32'h0001_0001, 1'b0, 1'b0, 1'b1, 2'b00, 2'd1, 1'b0, 1'b1, 1'b1);
        apply_stimulus(32'h0010_FF05, 32'h2001_0006, 1'b0, 1'b1, 1'b0, 2'b11, 2'd1, 1'b0, 1'b1, 1'b1);
        check("kadd16_vxsat", 32'(bus.vxsat_o), 32'h1);
        apply_stimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 1'b0, 1'b1, 1'b1);
        apply_stimulus(32'h0000_0000, 32'h0002_0002, 1'b0, 1'b0, 1'b0, 2'b11, 2'd2, 1'b0, 1'b1, 1'b1);
        apply_stimulus(32'h0005_0009, 32'h0003_0004, 1'b0, 1'b0, 1'b1, 2'b01, 2'd0, 1'b1, 1'b1, 1'b1);
        check("cras16_result", bus.result_o, 32'h0009_0006);
        idle(1'b1);

        // Backpressure: hold for 3 cycles with a new request pending
        apply_stimulus(32'h1234_5678, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // CSR clear coincides with a saturating retire
        bus.vxsat_we_i = 1'b1;
        idle(1'b1);
        bus.vxsat_we_i = 1'b0;
        check("vxsat_cleared", 32'(bus.vxsat_o), 32'h0);
        apply_stimulus(32'h7FFF_0001, 32'h0001_0001, 1'b0, 1'b0, 1'b1, 2'b00, 2'd1, 1'b0, 1'b1, 1'b1);
        bus.vxsat_we_i = 1'b1;
        idle(1'b1);
        bus.vxsat_we_i = 1'b0;
        check("vxsat_clr_vs_retire", 32'(bus.vxsat_o), 32'h1);

        // Random mix with random backpressure
        for (int i = 0; i < 16; i++)
            apply_stimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset while a result is held
        apply_stimulus(32'h7F7F_7F7F, 32'h0101_0101, 1'b0, 1'b1, 1'b1, 2'b00, 2'd1, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        check("midop_reset_valid", 32'(bus.valid_o), 32'h0);
        check("midop_reset_vxsat", 32'(bus.vxsat_o), 32'h0);
        check("midop_reset_result", bus.result_o, 32'h0);

        for (int i = 0; i < 8 && sb_q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        check("drain", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
